frac_clk_div: RTL and testbench

- Parametrised successor to the integer clock divider: fractional-N clock generator using a phase accumulator.
- Output frequency is f_in * inc / 2^ACC_WIDTH and can be reprogrammed at run time.
- Divisor changes are glitch-free: a new increment takes effect only at a period boundary.
- Provides a near-50% duty clock-enable-style output plus a one-cycle period tick; sits between the system clock and RFID baseband/modulator timing logic.

---
 rtl/frac_clk_div.sv | 194 +++++++++++++++++++
 tb/tb_frac_clk_div.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frac_clk_div.sv
// ---------------------------------------------------------------------------
// frac_clk_div -- fractional-N clock generator built on a phase accumulator.
//
// Output frequency is f_in * inc / 2^ACC_WIDTH. The increment can be changed
// at run time without glitches. A new value is held in a shadow register and
// only applied at a period boundary, or at once when the divider is idle,
// stopped or being cleared.
//
// Parameters:
//   ACC_WIDTH  accumulator / increment width (4..32)
//   RESET_INC  increment loaded at reset (must be < 2^ACC_WIDTH)
//
// Ports:
//   in_clk       system clock, all logic on its rising edge
//   rst_n        asynchronous active-low reset
//   en           advance the accumulator when high
//   sync_clr     synchronous phase clear (restart the period)
//   inc_in       new increment value
//   inc_load     one-cycle strobe that latches inc_in into the shadow register
//   inc_pending  a shadow increment is waiting to be applied
//   out_clk      divided clock, registered; high first, then low
//   out_tick     one-cycle pulse at each period start (accumulator wrap)
//   out_clk_q    quadrature clock, present only with FRAC_CLK_DIV_QUAD_EN
//
// Optional feature macro: FRAC_CLK_DIV_QUAD_EN adds out_clk_q.
// ---------------------------------------------------------------------------
module frac_clk_div #(
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned RESET_INC = 52
) (
    input  logic                 in_clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync_clr,
    input  logic [ACC_WIDTH-1:0] inc_in,
    input  logic                 inc_load,
    output logic                 inc_pending,
    output logic                 out_clk,
    output logic                 out_tick
`ifdef FRAC_CLK_DIV_QUAD_EN
    ,
    output logic                 out_clk_q
`endif
);

    // Largest legal increment: half the accumulator range gives f_in/2.
    localparam logic [ACC_WIDTH-1:0] INC_MAX   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [ACC_WIDTH-1:0] INC_RESET = ACC_WIDTH'(RESET_INC);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } upd_state_t;

    // Limit an increment so the output never exceeds f_in/2.
    function automatic logic [ACC_WIDTH-1:0] clamp_inc(input logic [ACC_WIDTH-1:0] value);
        logic [ACC_WIDTH-1:0] result;
        if (value > INC_MAX) begin
            result = INC_MAX;
        end else begin
            result = value;
        end
        return result;
    endfunction

    upd_state_t           state_r;
    upd_state_t           state_next_s;
    logic [ACC_WIDTH-1:0] acc_r;
    logic [ACC_WIDTH-1:0] acc_next_s;
    logic [ACC_WIDTH-1:0] inc_reg_r;
    logic [ACC_WIDTH-1:0] inc_next_s;
    logic [ACC_WIDTH-1:0] shadow_r;
    logic [ACC_WIDTH-1:0] shadow_next_s;
    logic [ACC_WIDTH:0]   sum_s;
    logic                 wrap_s;
    logic                 apply_evt_s;
    logic                 out_clk_r;
    logic                 out_clk_next_s;
    logic                 out_tick_r;
    logic                 out_tick_next_s;
`ifdef FRAC_CLK_DIV_QUAD_EN
    logic                 out_clk_q_r;
    logic                 out_clk_q_next_s;
`endif

    // Carry-out of the extra top bit marks the start of a new period.
    assign sum_s  = {1'b0, acc_r} + {1'b0, inc_reg_r};
    assign wrap_s = en & sum_s[ACC_WIDTH];

    // Boundaries at which a pending increment may be swapped in safely:
    // a wrap, a paused or stopped divider, or a phase clear.
    assign apply_evt_s = wrap_s | ~en | (inc_reg_r == {ACC_WIDTH{1'b0}}) | sync_clr;

    // Accumulator and output next-state, in sync_clr > en > hold priority.
    always_comb begin
        acc_next_s      = acc_r;
        out_clk_next_s  = out_clk_r;
        out_tick_next_s = 1'b0;
`ifdef FRAC_CLK_DIV_QUAD_EN
        out_clk_q_next_s = out_clk_q_r;
`endif
        if (sync_clr) begin
            acc_next_s      = {ACC_WIDTH{1'b0}};
            out_clk_next_s  = 1'b0;
            out_tick_next_s = 1'b0;
`ifdef FRAC_CLK_DIV_QUAD_EN
            out_clk_q_next_s = 1'b0;
`endif
        end else if (en) begin
            acc_next_s      = sum_s[ACC_WIDTH-1:0];
            // Inverted MSB: low half of the phase range is the high phase.
            out_clk_next_s  = ~sum_s[ACC_WIDTH-1];
            out_tick_next_s = sum_s[ACC_WIDTH];
`ifdef FRAC_CLK_DIV_QUAD_EN
            out_clk_q_next_s = sum_s[ACC_WIDTH-1] ^ sum_s[ACC_WIDTH-2];
`endif
        end else begin
            acc_next_s      = acc_r;
            out_clk_next_s  = out_clk_r;
            out_tick_next_s = 1'b0;
        end
    end

    // Shadow-increment update machine (IDLE/PENDING).
    always_comb begin
        state_next_s  = state_r;
        inc_next_s    = inc_reg_r;
        shadow_next_s = shadow_r;
        // A load always lands in the shadow; last write wins.
        if (inc_load) begin
            shadow_next_s = clamp_inc(inc_in);
        end else begin
            shadow_next_s = shadow_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (inc_load) begin
                    state_next_s = ST_PENDING;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (apply_evt_s) begin
                    // Old shadow goes live; a coincident load keeps us pending.
                    inc_next_s = shadow_r;
                    if (inc_load) begin
                        state_next_s = ST_PENDING;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_PENDING;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            acc_r      <= {ACC_WIDTH{1'b0}};
            inc_reg_r  <= INC_RESET;
            shadow_r   <= {ACC_WIDTH{1'b0}};
            out_clk_r  <= 1'b0;
            out_tick_r <= 1'b0;
`ifdef FRAC_CLK_DIV_QUAD_EN
            out_clk_q_r <= 1'b0;
`endif
        end else begin
            state_r    <= state_next_s;
            acc_r      <= acc_next_s;
            inc_reg_r  <= inc_next_s;
            shadow_r   <= shadow_next_s;
            out_clk_r  <= out_clk_next_s;
            out_tick_r <= out_tick_next_s;
`ifdef FRAC_CLK_DIV_QUAD_EN
            out_clk_q_r <= out_clk_q_next_s;
`endif
        end
    end

    assign inc_pending = (state_r == ST_PENDING);
    assign out_clk     = out_clk_r;
    assign out_tick    = out_tick_r;
`ifdef FRAC_CLK_DIV_QUAD_EN
    assign out_clk_q   = out_clk_q_r;
`endif

endmodule

// File: tb/tb_frac_clk_div.sv
// ---------------------------------------------------------------------------
// tb_frac_clk_div -- directed self-checking bench for frac_clk_div.
// Main instance uses ACC_WIDTH=8; a second ACC_WIDTH=16 instance checks the
// reset increment timing. Outputs are sampled 1 time unit after each rising
// edge, and inputs are changed at the same point.
// ---------------------------------------------------------------------------
module tb_frac_clk_div;

    logic       in_clk;
    logic       rst_n;
    logic       en;
    logic       sync_clr;
    logic [7:0] inc_in;
    logic       inc_load;
    logic       inc_pending;
    logic       out_clk;
    logic       out_tick;

    logic        en16;
    logic        sync_clr16;
    logic [15:0] inc_in16;
    logic        inc_load16;
    logic        inc_pending16;
    logic        out_clk16;
    logic        out_tick16;
`ifdef FRAC_CLK_DIV_QUAD_EN
    logic        out_clk_q;
    logic        out_clk_q16;
`endif

    int n_vec;
    int n_err;

    frac_clk_div #(.ACC_WIDTH(8), .RESET_INC(52)) dut (
        .in_clk      (in_clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync_clr    (sync_clr),
        .inc_in      (inc_in),
        .inc_load    (inc_load),
        .inc_pending (inc_pending),
        .out_clk     (out_clk),
        .out_tick    (out_tick)
`ifdef FRAC_CLK_DIV_QUAD_EN
        ,
        .out_clk_q   (out_clk_q)
`endif
    );

    frac_clk_div #(.ACC_WIDTH(16), .RESET_INC(52)) dut16 (
        .in_clk      (in_clk),
        .rst_n       (rst_n),
        .en          (en16),
        .sync_clr    (sync_clr16),
        .inc_in      (inc_in16),
        .inc_load    (inc_load16),
        .inc_pending (inc_pending16),
        .out_clk     (out_clk16),
        .out_tick    (out_tick16)
`ifdef FRAC_CLK_DIV_QUAD_EN
        ,
        .out_clk_q   (out_clk_q16)
`endif
    );

    // Free-running system clock, 10 time units per period.
    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    // Load an increment with en low, let it apply, then clear the phase.
    task automatic load_inc(input logic [7:0] value);
        en       = 1'b0;
        inc_load = 1'b1;
        inc_in   = value;
        step();
        inc_load = 1'b0;
        step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
    endtask

    initial begin
        int t_tick[3];
        int n_tick;
        int n_low;
        int n_high;
        int first8;
        int first16;

        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        sync_clr   = 1'b0;
        inc_in     = 8'd0;
        inc_load   = 1'b0;
        en16       = 1'b0;
        sync_clr16 = 1'b0;
        inc_in16   = 16'd0;
        inc_load16 = 1'b0;

        // Reset state, before any clock edge.
        #1;
        chk("rst_pending", int'(inc_pending), 0);
        chk("rst_clk", int'(out_clk), 0);
        chk("rst_tick", int'(out_tick), 0);
        #11;
        rst_n = 1'b1;

        // Integer divide by 4: load 64 while idle, applied on the next edge.
        inc_load = 1'b1;
        inc_in   = 8'd64;
        step();
        inc_load = 1'b0;
        chk("int_pend_set", int'(inc_pending), 1);
        step();
        chk("int_pend_clr", int'(inc_pending), 0);
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("int_clk_%0d", k), int'(out_clk), ((k % 4) == 0 || (k % 4) == 1) ? 1 : 0);
            chk($sformatf("int_tick_%0d", k), int'(out_tick), ((k % 4) == 0) ? 1 : 0);
`ifdef FRAC_CLK_DIV_QUAD_EN
            chk($sformatf("int_q_%0d", k), int'(out_clk_q), ((k % 4) == 1 || (k % 4) == 2) ? 1 : 0);
`endif
        end

        // Fractional: inc=3 gives tick intervals 86,85,85.
        load_inc(8'd3);
        en     = 1'b1;
        n_tick = 0;
        t_tick = '{0, 0, 0};
        for (int k = 1; k <= 768; k++) begin
            step();
            if (out_tick) begin
                if (n_tick < 3) t_tick[n_tick] = k;
                n_tick++;
            end
            if (k == 256) chk("frac_ticks_256", n_tick, 3);
        end
        chk("frac_iv0", t_tick[0], 86);
        chk("frac_iv1", t_tick[1] - t_tick[0], 85);
        chk("frac_iv2", t_tick[2] - t_tick[1], 85);
        chk("frac_ticks_768", n_tick, 9);

        // Glitch-free update from 64 to 32 one cycle after a tick.
        load_inc(8'd64);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        chk("glt_tick4", int'(out_tick), 1);
        inc_load = 1'b1;
        inc_in   = 8'd32;
        step();
        inc_load = 1'b0;
        chk("glt_pend5", int'(inc_pending), 1);
        step();
        chk("glt_pend6", int'(inc_pending), 1);
        step();
        chk("glt_pend7", int'(inc_pending), 1);
        chk("glt_tick7", int'(out_tick), 0);
        step();
        chk("glt_tick8", int'(out_tick), 1);
        chk("glt_pend8", int'(inc_pending), 0);
        for (int k = 9; k <= 16; k++) begin
            step();
            chk($sformatf("glt_clk_%0d", k), int'(out_clk), (k <= 11 || k == 16) ? 1 : 0);
            chk($sformatf("glt_tick_%0d", k), int'(out_tick), (k == 16) ? 1 : 0);
        end

        // Clamp: 0xC0 behaves as 0x80, toggling every cycle.
        load_inc(8'hC0);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("clamp_clk_%0d", k), int'(out_clk), ((k % 2) == 0) ? 1 : 0);
            chk($sformatf("clamp_tick_%0d", k), int'(out_tick), ((k % 2) == 0) ? 1 : 0);
        end
        // Stop: inc=0 applies at the next wrap, then output freezes high.
        inc_load = 1'b1;
        inc_in   = 8'd0;
        step();
        inc_load = 1'b0;
        chk("stop_pend", int'(inc_pending), 1);
        step();
        chk("stop_apply", int'(inc_pending), 0);
        chk("stop_last_tick", int'(out_tick), 1);
        n_tick = 0;
        n_low  = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_tick) n_tick++;
            if (!out_clk) n_low++;
        end
        chk("stop_no_ticks", n_tick, 0);
        chk("stop_clk_frozen", n_low, 0);
        // Restart from stopped: load applies on the very next edge.
        inc_load = 1'b1;
        inc_in   = 8'd64;
        step();
        inc_load = 1'b0;
        chk("restart_pend", int'(inc_pending), 1);
        step();
        chk("restart_apply", int'(inc_pending), 0);
        step();
        chk("restart_clk1", int'(out_clk), 1);
        step();
        chk("restart_clk2", int'(out_clk), 0);
        step();
        step();
        chk("restart_tick", int'(out_tick), 1);
        step();
        chk("pre_clr_clk", int'(out_clk), 1);

        // sync_clr beats en mid-period.
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        chk("clr_clk", int'(out_clk), 0);
        chk("clr_tick", int'(out_tick), 0);
        step();
        chk("clr_next_clk", int'(out_clk), 1);
        chk("clr_next_tick", int'(out_tick), 0);
        step();
        step();
        step();
        chk("clr_period_tick", int'(out_tick), 1);
        // en low for 10 cycles: hold.
        en     = 1'b0;
        n_tick = 0;
        n_high = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_tick) n_tick++;
            if (out_clk) n_high++;
        end
        chk("hold_ticks", n_tick, 0);
        chk("hold_clk", n_high, 10);
        en = 1'b1;
        step();
        chk("resume_clk1", int'(out_clk), 1);
        step();
        chk("resume_clk2", int'(out_clk), 0);

        // Async reset while out_clk=1 and a load is pending.
        step();
        step();
        inc_load = 1'b1;
        inc_in   = 8'd32;
        step();
        inc_load = 1'b0;
        chk("pre_rst_clk", int'(out_clk), 1);
        chk("pre_rst_pend", int'(inc_pending), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_clk", int'(out_clk), 0);
        chk("arst_pend", int'(inc_pending), 0);
        chk("arst_tick", int'(out_tick), 0);
        #4;
        rst_n = 1'b1;
        en    = 1'b1;
        en16  = 1'b1;
        first8  = 0;
        first16 = 0;
        for (int k = 1; k <= 1400; k++) begin
            step();
            if (k == 1) chk("r16_clk1", int'(out_clk16), 1);
            if (out_tick && first8 == 0) first8 = k;
            if (out_tick16 && first16 == 0) first16 = k;
            if (first16 != 0 && first8 != 0) break;
        end
        chk("r8_first_tick", first8, 5);
        chk("r16_first_tick", first16, 1261);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
